aes_text_out_serializer: RTL

//   Output-side companion to aes_cipher_top: captures the 128-bit text_out block on the done pulse and

---
 rtl/aes_text_out_serializer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/aes_text_out_serializer.sv
// Purpose : capture the 128-bit AES result on done and stream it MS word first as DATA_W-bit words.
// Latency : first word valid 1 cycle after done; one word per cycle while o_ready is held high.
// Backpr. : o_valid/o_data (and o_last) hold steady while o_ready=0; a done arriving mid-block
//           is dropped and flagged in the sticky ovf bit.
//
// Ports:
//   clk, rst       single rising-edge clock, asynchronous active-high reset
//   done, text_out 1-cycle result strobe from the cipher core and its 128-bit block
//   o_valid/o_data/o_ready  valid-ready word stream, word k = text_out[127-k*DATA_W -: DATA_W]
//   busy           block held and not fully drained (same as o_valid)
//   ovf, ovf_clr   sticky overrun flag and its synchronous clear (a new overrun wins)
//   o_last         marks the final word of a block; present only when AES_SER_LAST_EN is defined
//
// Parameter DATA_W must divide 128 (8, 16, 32, 64 or 128).
module aes_text_out_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [127:0]      text_out,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              o_ready,
    output logic              busy,
    output logic              ovf,
    input  logic              ovf_clr
`ifdef AES_SER_LAST_EN
    ,
    output logic              o_last
`endif
);

    localparam int NUM_WORDS = 128 / DATA_W;
    localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    logic [127:0]    buffer;
    logic [CW-1:0]   cnt;
    logic            hs;
    logic            final_hs;

    assign hs       = (state == SEND) && o_ready;
    assign final_hs = hs && (cnt == LAST);

    // The current word always sits in the top of the shift buffer, so o_data is a
    // straight register slice; after the final shift the buffer is all zeros.
    assign o_valid = (state == SEND);
    assign busy    = o_valid;
    assign o_data  = buffer[127 -: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            buffer <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            // A block is still held and this cycle does not retire it: drop the new
            // one. Setting takes priority over a simultaneous clear.
            if (done && (state == SEND) && !final_hs) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (done) begin
                        buffer <= text_out;
                        cnt    <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (done) begin
                                // Retiring the last word frees the buffer this very
                                // cycle, so the next block follows with no gap.
                                buffer <= text_out;
                            end else begin
                                buffer <= buffer << DATA_W;
                                state  <= IDLE;
                            end
                        end else begin
                            buffer <= buffer << DATA_W;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_SER_LAST_EN
    // Registered copy of "next word is the final one", updated on the same events
    // that move the word pointer so it holds steady through stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_last <= 1'b0;
        end else if (state == IDLE) begin
            if (done) begin
                o_last <= (NUM_WORDS == 1);
            end
        end else if (hs) begin
            if (cnt == LAST) begin
                o_last <= done && (NUM_WORDS == 1);
            end else begin
                o_last <= ((cnt + 1'b1) == LAST);
            end
        end
    end
`endif

endmodule
